// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALUOp constants and multiplier state encoding
package mips_pkg;

    localparam logic [4:0] ALUOP_MULT  = 5'b00010;
    localparam logic [4:0] ALUOP_MULTU = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_t;

    function automatic logic is_mult_op(input logic [4:0] op);
        return (op == ALUOP_MULT) || (op == ALUOP_MULTU);
    endfunction

endpackage

// File: rtl/shift_add_mult_core.sv
// rtl/shift_add_mult_core.sv - unsigned radix-2 shift-add multiplier datapath
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          capture multiplicand/multiplier, clear accumulator and counter
//   step          retire one multiplier bit
//   multiplicand  unsigned WIDTH-bit operand
//   multiplier    unsigned WIDTH-bit operand
//   product       2*WIDTH-bit result, valid after WIDTH steps
//   last          high during the step that retires the final multiplier bit
module shift_add_mult_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;

    // Upper half accumulates; lower half starts as the multiplier and is
    // shifted out LSB-first as product bits shift in from the top.
    always_comb begin
        sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, (product[0] ? mcand : '0)};
    end

    assign last = step && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= multiplicand;
            product <= {{WIDTH{1'b0}}, multiplier};
            count   <= '0;
        end else if (step) begin
            product <= {sum, product[WIDTH-1:1]};
            count   <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - iterative signed/unsigned multiplier with HI/LO registers
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Start, ALUOp      request strobe; only MULT/MULTU start an operation
//   A, B              rs / rt operands (A is also MTHI/MTLO data)
//   WriteHi, WriteLo  MTHI / MTLO strobes, honoured only when not busy
//   Hi, Lo            HI / LO registers
//   Busy              operation in flight (RUN or FIX)
//   Done              one-cycle pulse after Hi/Lo take the new product
module mult_hilo_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WriteHi,
    input  logic             WriteLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    mult_state_t        state;
    logic               neg;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fixed;
    logic               core_last;

    assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && Start && is_mult_op(ALUOp);
    assign signed_op = (ALUOp == ALUOP_MULT);

    // Magnitudes are held unsigned, so the most negative value maps onto
    // itself and is still the correct magnitude.
    assign a_mag = (signed_op && A[WIDTH-1]) ? -A : A;
    assign b_mag = (signed_op && B[WIDTH-1]) ? -B : B;

    assign prod_fixed = neg ? -product : product;

    shift_add_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk          (Clk),
        .rst          (Reset),
        .load         (accept),
        .step         (state == ST_RUN),
        .multiplicand (a_mag),
        .multiplier   (b_mag),
        .product      (product),
        .last         (core_last)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            neg   <= 1'b0;
            Hi    <= '0;
            Lo    <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        neg   <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        Busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        // MT* writes only land when no multiply is being accepted.
                        if (WriteHi) Hi <= A;
                        if (WriteLo) Lo <= A;
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (core_last) state <= ST_FIX;
                end
                ST_FIX: begin
                    Hi    <= prod_fixed[2*WIDTH-1:WIDTH];
                    Lo    <= prod_fixed[WIDTH-1:0];
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - scoreboard bench for mult_hilo_unit
module tb_mult_hilo_unit;

    localparam logic [4:0] OP_MULT  = 5'b00010;
    localparam logic [4:0] OP_MULTU = 5'b01101;

    logic        Clk = 1'b0;
    logic        Reset, Start, WriteHi, WriteLo;
    logic [4:0]  ALUOp;
    logic [31:0] A, B, Hi, Lo;
    logic        Busy, Done;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc;
    logic [63:0] exp_q[$];

    mult_hilo_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .ALUOp   (ALUOp),
        .A       (A),
        .B       (B),
        .WriteHi (WriteHi),
        .WriteLo (WriteLo),
        .Hi      (Hi),
        .Lo      (Lo),
        .Busy    (Busy),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding product.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: Done high with Hi=0x%h Lo=0x%h, expected no pulse", Hi, Lo);
            end else begin
                check("product", {Hi, Lo}, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [63:0] exp);
        Start = 1'b1;
        ALUOp = op;
        A     = a;
        B     = b;
        if (push) exp_q.push_back(exp);
        tick();
        Start = 1'b0;
        ALUOp = 5'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        ALUOp = 5'b0; A = '0; B = '0;
        tick(); tick();
        check("reset_hi", 64'(Hi), 64'h0);
        check("reset_lo", 64'(Lo), 64'h0);
        check("reset_busy", 64'(Busy), 64'h0);
        check("reset_done", 64'(Done), 64'h0);
        Reset = 1'b0;
        tick();

        // -3 * 7 = -21
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB);
        wait_idle(cyc);
        check("busy_cycles", 64'(cyc), 64'd33);
        check("done_high", 64'(Done), 64'h1);
        tick();
        check("done_one_cycle", 64'(Done), 64'h0);

        // MULTU then MULT of all-ones, back to back on the DONE cycle
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
        wait_idle(cyc);
        issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001);
        wait_idle(cyc);
        tick();

        // most negative squared
        issue(OP_MULT, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        wait_idle(cyc);
        tick();

        // non-multiply ALUOp is ignored
        issue(5'b00000, 32'd1, 32'd2, 1'b0, 64'h0);
        check("ignored_op_busy", 64'(Busy), 64'h0);
        tick();
        check("ignored_op_hilo", {Hi, Lo}, 64'h40000000_00000000);

        // MTHI / MTLO in idle
        WriteHi = 1'b1; A = 32'h12345678;
        tick();
        WriteHi = 1'b0;
        check("mthi", 64'(Hi), 64'h12345678);
        WriteLo = 1'b1; A = 32'h0000ABCD;
        tick();
        WriteLo = 1'b0;
        check("mtlo", 64'(Lo), 64'h0000ABCD);
        check("mtlo_hi_kept", 64'(Hi), 64'h12345678);

        // MTLO during RUN is dropped
        issue(OP_MULT, 32'd2, 32'd5, 1'b1, 64'd10);
        repeat (3) tick();
        WriteLo = 1'b1; A = 32'h0000DEAD;
        tick();
        WriteLo = 1'b0;
        check("mtlo_busy_lo", 64'(Lo), 64'h0000ABCD);
        check("mtlo_busy_hi", 64'(Hi), 64'h12345678);
        wait_idle(cyc);
        tick();

        // reset in the middle of RUN abandons the operation
        issue(OP_MULT, 32'd9, 32'd9, 1'b0, 64'h0);
        repeat (10) tick();
        Reset = 1'b1;
        #1;
        check("midrun_reset_busy", 64'(Busy), 64'h0);
        check("midrun_reset_hilo", {Hi, Lo}, 64'h0);
        tick();
        Reset = 1'b0;
        repeat (40) tick();
        check("midrun_reset_idle", 64'(Busy), 64'h0);
        issue(OP_MULT, 32'd6, 32'd7, 1'b1, 64'd42);
        wait_idle(cyc);
        tick();

        // Start while busy is ignored
        issue(OP_MULTU, 32'd4, 32'd5, 1'b1, 64'd20);
        repeat (5) tick();
        Start = 1'b1; ALUOp = OP_MULTU; A = 32'd2; B = 32'd3;
        tick();
        Start = 1'b0; ALUOp = 5'b0;
        wait_idle(cyc);
        check("busy_start_len", 64'(cyc), 64'd27);
        repeat (40) tick();
        check("busy_start_idle", 64'(Busy), 64'h0);

        // back-to-back accept on the DONE cycle
        issue(OP_MULT, 32'd3, 32'hFFFFFFFC, 1'b1, 64'hFFFFFFFF_FFFFFFF4);
        wait_idle(cyc);
        check("b2b_done", 64'(Done), 64'h1);
        issue(OP_MULTU, 32'h00010000, 32'h00010000, 1'b1, 64'h00000001_00000000);
        wait_idle(cyc);
        check("b2b_busy_cycles", 64'(cyc), 64'd33);
        tick();

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            cyc++;
            tick();
        end
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
